let_toggle_checker: RTL and testbench
=====================================

Name: let_toggle_checker

Overview:
- Synthesizable RTL monitor that sits directly downstream of the let/property test modules.
- Consumes the same signals those modules assert on: a, b (16-bit) and c, d (1-bit).
- Evaluates in hardware the equivalents of the ones_match immediate assertion (a == b) and the toggles property (same(c,d) |=> !same(c,d)).
- Reports per-cycle failure pulses, saturating failure counters and a first-failure capture, so emulation/FPGA runs can check the same rules without a simulator.

Parameters:
- WIDTH, 16, width of a and b.
- CNT_W, 8, width of the failure counters; they saturate at 2^CNT_W-1.
- IDX_W, 16, width of the enabled-cycle index counter used for first-failure capture.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; the checker evaluates only on cycles with en=1.
- clr  input  1  synchronous clear of counters, sticky flag, capture and obligation.
- a  input  WIDTH  first operand of ones_match.
- b  input  WIDTH  second operand of ones_match.
- c  input  1  first operand of same.
- d  input  1  second operand of same.
- a1_fail  output  1  one-cycle pulse: ones_match failed on the previous enabled sample.
- a2_fail  output  1  one-cycle pulse: toggles obligation violated on the previous sample.
- a1_cnt  output  CNT_W  saturating count of a1 failures.
- a2_cnt  output  CNT_W  saturating count of a2 failures.
- err_sticky  output  1  set by any failure; held until clr or reset.
- first_fail_vld  output  1  first_fail_idx holds a valid capture.
- first_fail_idx  output  IDX_W  enabled-cycle index of the first failure of either kind.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs and counters go to 0, state goes to IDLE, idx goes to 0.
- Reset asserted mid-operation discards any pending obligation immediately.
- Equality is 2-state. X/Z is not modelled; the bench drives known values only.
- idx counter: increments by 1 on every cycle with en=1 and wraps at 2^IDX_W. The current idx is the index of the sample taken this cycle; the first enabled sample after reset or clr has index 0.
- a1 check:
  - On an enabled cycle with a != b, a1_fail=1 on the next cycle.
  - a1_cnt increments, saturating.
- State machine, 2 states:
  - IDLE: on an enabled cycle with c == d, go to ARMED (obligation pending); otherwise stay.
  - ARMED, next cycle with en=1:
    - If c == d: fire a2_fail next cycle and increment a2_cnt. The same sample creates a fresh obligation (overlapping), so stay in ARMED.
    - If c != d: obligation met; go to IDLE.
  - ARMED, next cycle with en=0: obligation discarded (disable semantics), no failure, go to IDLE.
- Latency: both fail pulses are registered, exactly 1 cycle after the offending sample. Counters, err_sticky and the capture update on that same edge.
- Simultaneous a1 and a2 failure on one sample:
  - Both pulses assert.
  - Both counters increment.
  - first_fail_idx captures once.
- first_fail_idx: loaded with the sample's idx only when first_fail_vld=0; it then holds.
- Saturation: a counter at its all-ones value stays there. It does not wrap.
- clr=1:
  - On the next edge, counters, err_sticky, first_fail_vld, first_fail_idx and idx go to 0, and state goes to IDLE.
  - clr has priority over any failure detected in the same cycle: that sample is not evaluated and fail pulses are 0 next cycle.
  - Fail pulses already registered from the previous cycle are still visible during the clr cycle.
- en=0: a, b, c, d are ignored; the idx counter holds.

Test Plan:
- Reset then en=1, a=b=16'h1234, c/d alternating equal/unequal (1/1, 0/1, 1/1, 1/0) for 8 cycles -> no fail pulses, counters 0, err_sticky 0.
- c=d=1 for 3 consecutive enabled cycles starting at idx 0 -> a2_fail high on the cycles after samples 1 and 2; a2_cnt=2; first_fail_idx=1, first_fail_vld=1.
- Sample 5 with a=16'h00FF, b=16'h00FE and c=d so that samples 4 and 5 are both equal -> a1_fail and a2_fail both pulse the next cycle; each counter increments by 1; first_fail_idx=5.
- c=d at sample 0, then en=0 for one cycle, then c=d again -> no a2_fail (obligation discarded); state returns to IDLE.
- Force 300 a1 failures with CNT_W=8 -> a1_cnt stops at 255; then assert clr on the same cycle as a failing sample -> next cycle a1_cnt=0, a1_fail=0, err_sticky=0.
- Drive rst_n low asynchronously mid-cycle while ARMED with a2_cnt=3 -> all outputs 0 immediately; after release, the first c!=d sample produces no fail.

Source files
------------

// File: rtl/let_toggle_checker.sv
// let_toggle_checker: hardware monitor for the ones_match (a == b) check and the
// toggles property (same(c,d) |=> !same(c,d)). Produces registered failure pulses,
// saturating failure counters, a sticky error flag and a first-failure index capture.
module let_toggle_checker #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             d,
  output logic             a1_fail,
  output logic             a2_fail,
  output logic [CNT_W-1:0] a1_cnt,
  output logic [CNT_W-1:0] a2_cnt,
  output logic             err_sticky,
  output logic             first_fail_vld,
  output logic [IDX_W-1:0] first_fail_idx
);

  typedef enum logic [0:0] {StIdle, StArmed} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             a1_fail_q, a2_fail_q;
  logic [CNT_W-1:0] a1_cnt_q, a1_cnt_d;
  logic [CNT_W-1:0] a2_cnt_q, a2_cnt_d;
  logic             sticky_q, sticky_d;
  logic             ffv_q, ffv_d;
  logic [IDX_W-1:0] ffi_q, ffi_d;

  logic eval;
  logic same;
  logic a1_hit;
  logic a2_hit;
  logic any_hit;

  // A sample is evaluated only when enabled and not being cleared (clr wins).
  assign eval    = en && !clr;
  assign same    = (c == d);
  assign a1_hit  = eval && (a != b);
  assign any_hit = a1_hit || a2_hit;

  // Obligation tracking: a disabled cycle discards any pending obligation.
  always_comb begin
    state_d = state_q;
    a2_hit  = 1'b0;
    if (clr || !en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (same) state_d = StArmed;
        end
        StArmed: begin
          if (same) begin
            // Violation; the same sample opens a fresh obligation.
            a2_hit  = 1'b1;
            state_d = StArmed;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Next-state for idx, saturating counters, sticky flag and first-failure capture.
  always_comb begin
    idx_d    = idx_q;
    a1_cnt_d = a1_cnt_q;
    a2_cnt_d = a2_cnt_q;
    sticky_d = sticky_q;
    ffv_d    = ffv_q;
    ffi_d    = ffi_q;
    if (clr) begin
      idx_d    = '0;
      a1_cnt_d = '0;
      a2_cnt_d = '0;
      sticky_d = 1'b0;
      ffv_d    = 1'b0;
      ffi_d    = '0;
    end else begin
      if (en) idx_d = idx_q + IDX_W'(1);
      if (a1_hit && (a1_cnt_q != '1)) a1_cnt_d = a1_cnt_q + CNT_W'(1);
      if (a2_hit && (a2_cnt_q != '1)) a2_cnt_d = a2_cnt_q + CNT_W'(1);
      if (any_hit) sticky_d = 1'b1;
      if (any_hit && !ffv_q) begin
        ffv_d = 1'b1;
        ffi_d = idx_q;
      end
    end
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      a1_fail_q <= 1'b0;
      a2_fail_q <= 1'b0;
      a1_cnt_q  <= '0;
      a2_cnt_q  <= '0;
      sticky_q  <= 1'b0;
      ffv_q     <= 1'b0;
      ffi_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a1_fail_q <= a1_hit;
      a2_fail_q <= a2_hit;
      a1_cnt_q  <= a1_cnt_d;
      a2_cnt_q  <= a2_cnt_d;
      sticky_q  <= sticky_d;
      ffv_q     <= ffv_d;
      ffi_q     <= ffi_d;
    end
  end

  assign a1_fail        = a1_fail_q;
  assign a2_fail        = a2_fail_q;
  assign a1_cnt         = a1_cnt_q;
  assign a2_cnt         = a2_cnt_q;
  assign err_sticky     = sticky_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_let_toggle_checker.sv
// Self-checking bench for let_toggle_checker: directed vectors, a history-based
// reference model compared every cycle, plus hand-computed literal expectations.
module tb_let_toggle_checker;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
  localparam int IDX_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             en    = 1'b0;
  logic             clr   = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             c     = 1'b0;
  logic             d     = 1'b0;
  logic             a1_fail, a2_fail, err_sticky, first_fail_vld;
  logic [CNT_W-1:0] a1_cnt, a2_cnt;
  logic [IDX_W-1:0] first_fail_idx;

  int checks   = 0;
  int failures = 0;

  let_toggle_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .en             (en),
    .clr            (clr),
    .a              (a),
    .b              (b),
    .c              (c),
    .d              (d),
    .a1_fail        (a1_fail),
    .a2_fail        (a2_fail),
    .a1_cnt         (a1_cnt),
    .a2_cnt         (a2_cnt),
    .err_sticky     (err_sticky),
    .first_fail_vld (first_fail_vld),
    .first_fail_idx (first_fail_idx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a2 fails when this sample and the immediately preceding
  // cycle's sample were both evaluated (en=1, clr=0) and both had c == d.
  int m_idx, m_a1_cnt, m_a2_cnt, m_ffi;
  bit m_a1_fail, m_a2_fail, m_sticky, m_ffv;
  bit prev_eval, prev_same;

  always @(posedge clock or negedge rst_n) begin
    bit ev, h1, h2;
    if (!rst_n) begin
      m_idx = 0; m_a1_cnt = 0; m_a2_cnt = 0; m_ffi = 0;
      m_a1_fail = 0; m_a2_fail = 0; m_sticky = 0; m_ffv = 0;
      prev_eval = 0; prev_same = 0;
    end else begin
      ev = en && !clr;
      h1 = ev && (a != b);
      h2 = ev && (c == d) && prev_eval && prev_same;
      m_a1_fail = h1;
      m_a2_fail = h2;
      if (clr) begin
        m_a1_cnt = 0; m_a2_cnt = 0; m_sticky = 0; m_ffv = 0; m_ffi = 0; m_idx = 0;
      end else begin
        if (h1) m_a1_cnt = (m_a1_cnt < CMAX) ? m_a1_cnt + 1 : CMAX;
        if (h2) m_a2_cnt = (m_a2_cnt < CMAX) ? m_a2_cnt + 1 : CMAX;
        if (h1 || h2) begin
          m_sticky = 1;
          if (!m_ffv) begin
            m_ffv = 1;
            m_ffi = m_idx;
          end
        end
        if (en) m_idx = (m_idx + 1) % (1 << IDX_W);
      end
      prev_eval = ev;
      prev_same = (c == d);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    chk("a1_fail", int'(a1_fail), int'(m_a1_fail));
    chk("a2_fail", int'(a2_fail), int'(m_a2_fail));
    chk("a1_cnt", int'(a1_cnt), m_a1_cnt);
    chk("a2_cnt", int'(a2_cnt), m_a2_cnt);
    chk("err_sticky", int'(err_sticky), int'(m_sticky));
    chk("first_fail_vld", int'(first_fail_vld), int'(m_ffv));
    chk("first_fail_idx", int'(first_fail_idx), m_ffi);
  end

  // Drive one cycle of inputs; returns shortly after the following negedge.
  task automatic step(input bit e, input bit cl, input logic [WIDTH-1:0] va,
                      input logic [WIDTH-1:0] vb, input bit vc, input bit vd);
    en = e; clr = cl; a = va; b = vb; c = vc; d = vd;
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  initial begin
    // Reset.
    repeat (2) @(negedge clock);
    #2 rst_n = 1'b1;
    @(negedge clock); #1;
    chk("reset_a1_cnt", int'(a1_cnt), 0);
    chk("reset_vld", int'(first_fail_vld), 0);

    // 1: equal operands, c/d alternating equal/unequal -> no failures.
    for (int r = 0; r < 2; r++) begin
      step(1, 0, 16'h1234, 16'h1234, 1, 1);
      step(1, 0, 16'h1234, 16'h1234, 0, 1);
      step(1, 0, 16'h1234, 16'h1234, 1, 1);
      step(1, 0, 16'h1234, 16'h1234, 1, 0);
    end
    chk("t1_a1_cnt", int'(a1_cnt), 0);
    chk("t1_a2_cnt", int'(a2_cnt), 0);
    chk("t1_sticky", int'(err_sticky), 0);

    // 2: c=d for samples 0..2 -> failures after samples 1 and 2.
    step(1, 1, 16'h1234, 16'h1234, 0, 1);
    step(1, 0, 16'h1234, 16'h1234, 1, 1);
    chk("t2_s0_a2_fail", int'(a2_fail), 0);
    step(1, 0, 16'h1234, 16'h1234, 1, 1);
    chk("t2_s1_a2_fail", int'(a2_fail), 1);
    step(1, 0, 16'h1234, 16'h1234, 1, 1);
    chk("t2_s2_a2_fail", int'(a2_fail), 1);
    chk("t2_a2_cnt", int'(a2_cnt), 2);
    chk("t2_ffi", int'(first_fail_idx), 1);
    chk("t2_vld", int'(first_fail_vld), 1);
    step(1, 0, 16'h1234, 16'h1234, 0, 1);
    chk("t2_met_a2_fail", int'(a2_fail), 0);

    // 3: simultaneous a1 and a2 failure on sample 5.
    step(1, 1, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 16'h0055, 16'h0055, 1, 0);
    step(1, 0, 16'h0055, 16'h0055, 1, 1);
    step(1, 0, 16'h00FF, 16'h00FE, 0, 0);
    chk("t3_a1_fail", int'(a1_fail), 1);
    chk("t3_a2_fail", int'(a2_fail), 1);
    chk("t3_a1_cnt", int'(a1_cnt), 1);
    chk("t3_a2_cnt", int'(a2_cnt), 1);
    chk("t3_ffi", int'(first_fail_idx), 5);

    // 4: en=0 discards the obligation; operands ignored while disabled.
    step(1, 1, 16'h0, 16'h0, 0, 1);
    step(1, 0, 16'h0, 16'h0, 1, 1);
    step(0, 0, 16'hAAAA, 16'h5555, 1, 1);
    chk("t4_dis_a1_fail", int'(a1_fail), 0);
    step(1, 0, 16'h0, 16'h0, 1, 1);
    chk("t4_a2_fail", int'(a2_fail), 0);
    chk("t4_sticky", int'(err_sticky), 0);
    step(1, 0, 16'h0, 16'h0, 0, 1);
    chk("t4_idle_a2_fail", int'(a2_fail), 0);

    // 5: saturation, then clr on a failing sample.
    for (int i = 0; i < 300; i++) step(1, 0, 16'(i), 16'(i + 1), 0, 1);
    chk("t5_sat", int'(a1_cnt), 255);
    chk("t5_pulse_before_clr", int'(a1_fail), 1);
    step(1, 1, 16'h0001, 16'h0002, 0, 1);
    chk("t5_clr_a1_cnt", int'(a1_cnt), 0);
    chk("t5_clr_a1_fail", int'(a1_fail), 0);
    chk("t5_clr_sticky", int'(err_sticky), 0);

    // 6: asynchronous reset while armed with a2_cnt=3.
    for (int i = 0; i < 4; i++) step(1, 0, 16'h7, 16'h7, 0, 0);
    chk("t6_a2_cnt", int'(a2_cnt), 3);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_a2_cnt", int'(a2_cnt), 0);
    chk("t6_rst_a2_fail", int'(a2_fail), 0);
    chk("t6_rst_sticky", int'(err_sticky), 0);
    chk("t6_rst_vld", int'(first_fail_vld), 0);
    #1 rst_n = 1'b1;
    step(1, 0, 16'h7, 16'h7, 1, 1);
    step(1, 0, 16'h7, 16'h7, 0, 1);
    chk("t6_post_a2_fail", int'(a2_fail), 0);
    chk("t6_post_a2_cnt", int'(a2_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
